uart_tx_arbiter: RTL

Round-robin scheduler that shares one uart_tx serializer among N_REQ byte-stream requesters. Each requester has a valid/ready/last byte interface. The arbiter picks a winner, hands its byte to uart_tx as a one-cycle tvalid pulse, then holds off until uart_tx goes idle again. Optional packet lock keeps the grant on one requester until it sends tlast, so multi-byte messages are never interleaved on the line.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM encoding and grant-index width.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_ARB        = 2'd0,
      ST_ISSUE      = 2'd1,
      ST_WAIT_START = 2'd2,
      ST_WAIT_DONE  = 2'd3
   } arb_state_e;

   // Index width for n requesters, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between byte requesters, the arbiter and the uart_tx serializer.
// Handshake: a byte moves on a posedge where s_tvalid[i] & s_tready[i]; uart_tvalid is a one-cycle start pulse.
interface uart_tx_arbiter_if import uart_pkg::*; #(
   parameter int N_REQ = 4,
   parameter int GW    = idx_w(N_REQ)
);
   logic [8*N_REQ-1:0] s_tdata;
   logic [N_REQ-1:0]   s_tvalid;
   logic [N_REQ-1:0]   s_tlast;
   logic [N_REQ-1:0]   s_tready;
   logic [7:0]         uart_tdata;
   logic               uart_tvalid;
   logic               uart_busy;
   logic [GW-1:0]      grant_id;
   logic               locked;
   logic               err_start;

   modport master (
      input  s_tdata, s_tvalid, s_tlast, uart_busy,
      output s_tready, uart_tdata, uart_tvalid, grant_id, locked, err_start
   );

   modport slave (
      output s_tdata, s_tvalid, s_tlast, uart_busy,
      input  s_tready, uart_tdata, uart_tvalid, grant_id, locked, err_start
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr, wrapping.
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [N-1:0] gnt_o,
   output logic [W-1:0] gnt_idx_o,
   output logic         any_o
);

   always_comb begin
      int j;
      gnt_o     = '0;
      gnt_idx_o = '0;
      any_o     = 1'b0;
      j         = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr_i) + k;
         if (j >= N) j = j - N;
         if (!any_o && req_i[j]) begin
            gnt_o[j]  = 1'b1;
            gnt_idx_o = W'(j);
            any_o     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among N_REQ byte streams, with optional packet lock.
module uart_tx_arbiter import uart_pkg::*; #(
   parameter int  N_REQ         = 4,
   parameter int  LOCK_ON_PKT   = 1,
   parameter int  START_TIMEOUT = 4,
   localparam int GW            = idx_w(N_REQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   uart_tx_arbiter_if.master   bus,
   output arb_state_e          dbg_state_o,
   output logic [GW-1:0]       dbg_rr_ptr_o
);

   localparam int             CW       = $clog2(START_TIMEOUT + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(START_TIMEOUT - 1);

   arb_state_e      state_q, state_d;
   logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [7:0]      data_q, data_d;
   logic            tlast_q, tlast_d;
   logic            locked_q, locked_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [N_REQ-1:0] own_mask, cand, pick_gnt;
   logic [GW-1:0]    pick_idx, next_ptr;
   logic             pick_any;

   // While locked only the current owner may compete.
   assign own_mask = N_REQ'(1) << grant_q;
   assign cand     = locked_q ? (bus.s_tvalid & own_mask) : bus.s_tvalid;
   assign next_ptr = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

   rr_pick #(.N(N_REQ), .W(GW)) u_pick (
      .req_i     (cand),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (pick_gnt),
      .gnt_idx_o (pick_idx),
      .any_o     (pick_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_ARB;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         data_q   <= '0;
         tlast_q  <= 1'b0;
         locked_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         data_q   <= data_d;
         tlast_q  <= tlast_d;
         locked_q <= locked_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      rr_ptr_d        = rr_ptr_q;
      grant_d         = grant_q;
      data_d          = data_q;
      tlast_d         = tlast_q;
      locked_d        = locked_q;
      cnt_d           = cnt_q;
      bus.s_tready    = '0;
      bus.uart_tvalid = 1'b0;
      bus.err_start   = 1'b0;
      case (state_q)
         ST_ARB: begin
            if (!bus.uart_busy && pick_any) begin
               bus.s_tready = pick_gnt;
               data_d       = bus.s_tdata[{pick_idx, 3'b000} +: 8];
               grant_d      = pick_idx;
               tlast_d      = bus.s_tlast[pick_idx];
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            bus.uart_tvalid = 1'b1;
            cnt_d           = '0;
            state_d         = ST_WAIT_START;
         end
         ST_WAIT_START: begin
            if (bus.uart_busy) begin
               cnt_d   = '0;
               state_d = ST_WAIT_DONE;
            end else if (cnt_q == CNT_LAST) begin
               // Serializer never started: drop the byte and abandon any packet lock.
               bus.err_start = 1'b1;
               locked_d      = 1'b0;
               rr_ptr_d      = next_ptr;
               cnt_d         = '0;
               state_d       = ST_ARB;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (!bus.uart_busy) begin
               locked_d = (LOCK_ON_PKT != 0) && !tlast_q;
               if (!locked_d) rr_ptr_d = next_ptr;
               state_d = ST_ARB;
            end
         end
         default: state_d = ST_ARB;
      endcase
   end

   assign bus.uart_tdata = data_q;
   assign bus.grant_id   = grant_q;
   assign bus.locked     = locked_q;
   assign dbg_state_o    = state_q;
   assign dbg_rr_ptr_o   = rr_ptr_q;

endmodule
